// File: rtl/line_animator_if.sv
// Line-drawer handshake and framebuffer write port shared by the animator
// (master) and the drawer/framebuffer side (slave).
interface line_animator_if;
   localparam int unsigned COORD_W = 11;

   logic               ld_start;
   logic [COORD_W-1:0] ld_x0;
   logic [COORD_W-1:0] ld_y0;
   logic [COORD_W-1:0] ld_x1;
   logic [COORD_W-1:0] ld_y1;
   logic               ld_done;
   logic [COORD_W-1:0] ld_x;
   logic [COORD_W-1:0] ld_y;
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic               pix_color;
   logic               pix_we;

   modport master (
      output ld_start, ld_x0, ld_y0, ld_x1, ld_y1,
      output pix_x, pix_y, pix_color, pix_we,
      input  ld_done, ld_x, ld_y
   );

   modport slave (
      input  ld_start, ld_x0, ld_y0, ld_x1, ld_y1,
      input  pix_x, pix_y, pix_color, pix_we,
      output ld_done, ld_x, ld_y
   );
endinterface

// File: rtl/line_animator.sv
// Sweeps a line across the screen: clear once, then repeatedly draw, hold,
// erase and advance the endpoint position.
module line_animator #(
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned STEP        = 4,
   parameter int unsigned WAIT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic pause,
   line_animator_if.master bus
);
   localparam int unsigned CW     = 11;
   localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_CLEAR, S_LOAD_D, S_DRAW, S_HOLD, S_LOAD_E, S_ERASE, S_ADVANCE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CW-1:0]     rast_x;
   logic [CW-1:0]     rast_y;
   logic [CW-1:0]     pos;
   logic [CW-1:0]     held_x;
   logic [CW-1:0]     held_y;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CW:0]       pos_sum;
   logic [CW-1:0]     pos_next;
   logic              raster_last;
   logic              hold_exp;
   logic              writing;

   // One extra bit on the sum so a wrap near 2047 cannot alias below the limit
   assign pos_sum     = {1'b0, pos} + (CW+1)'(STEP);
   assign pos_next    = (pos_sum > (CW+1)'(SCREEN_W - 1)) ? '0 : pos_sum[CW-1:0];
   assign raster_last = (rast_x == CW'(SCREEN_W - 1)) && (rast_y == CW'(SCREEN_H - 1));
   assign hold_exp    = !pause && (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
   assign writing     = (state == S_CLEAR) || (state == S_DRAW) || (state == S_ERASE);

   assign bus.ld_x0 = pos;
   assign bus.ld_y0 = '0;
   assign bus.ld_x1 = CW'(SCREEN_W - 1) - pos;
   assign bus.ld_y1 = CW'(SCREEN_H - 1);

   always_ff @(posedge clk) begin
      if (reset) state <= S_CLEAR;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_CLEAR:   if (raster_last) state_nxt = S_LOAD_D;
         S_LOAD_D:  state_nxt = S_DRAW;
         S_DRAW:    if (bus.ld_done) state_nxt = S_HOLD;
         S_HOLD:    if (hold_exp) state_nxt = S_LOAD_E;
         S_LOAD_E:  state_nxt = S_ERASE;
         S_ERASE:   if (bus.ld_done) state_nxt = S_ADVANCE;
         S_ADVANCE: state_nxt = S_LOAD_D;
         default:   state_nxt = S_CLEAR;
      endcase
   end

   // Reset overrides the state decode so the drawer is held in load meanwhile
   always_comb begin
      bus.ld_start  = 1'b0;
      bus.pix_we    = 1'b0;
      bus.pix_color = 1'b0;
      bus.pix_x     = held_x;
      bus.pix_y     = held_y;
      case (state)
         S_CLEAR: begin
            bus.pix_we = 1'b1;
            bus.pix_x  = rast_x;
            bus.pix_y  = rast_y;
         end
         S_LOAD_D, S_LOAD_E: bus.ld_start = 1'b1;
         S_DRAW, S_ERASE: begin
            bus.pix_x     = bus.ld_x;
            bus.pix_y     = bus.ld_y;
            bus.pix_color = (state == S_DRAW);
            bus.pix_we    = !bus.ld_done;
         end
         default: ;
      endcase
      if (reset) begin
         bus.ld_start  = 1'b1;
         bus.pix_we    = 1'b0;
         bus.pix_color = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rast_x   <= '0;
         rast_y   <= '0;
         wait_cnt <= '0;
         pos      <= '0;
         held_x   <= '0;
         held_y   <= '0;
      end else begin
         if (state == S_CLEAR) begin
            if (rast_x == CW'(SCREEN_W - 1)) begin
               rast_x <= '0;
               rast_y <= (rast_y == CW'(SCREEN_H - 1)) ? '0 : rast_y + CW'(1);
            end else begin
               rast_x <= rast_x + CW'(1);
            end
         end
         if (state == S_HOLD) begin
            if (!pause) wait_cnt <= hold_exp ? '0 : wait_cnt + WAIT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (state == S_ADVANCE) pos <= pos_next;
         if (writing) begin
            held_x <= bus.pix_x;
            held_y <= bus.pix_y;
         end
      end
   end
endmodule

// File: tb/tb_line_animator.sv
// Randomized-pause bench for line_animator: a timeline model predicts every
// framebuffer write and drawer load; a negedge monitor scores the DUT against it.
module tb_line_animator;
   localparam int SW   = 8;
   localparam int SH   = 6;
   localparam int ST   = 3;
   localparam int WC   = 4;
   localparam int MAXC = 4096;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic pause = 1'b0;

   line_animator_if bus();

   line_animator #(
      .SCREEN_W(SW), .SCREEN_H(SH), .STEP(ST), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk), .reset(reset), .pause(pause), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y;} pt_t;
   typedef pt_t pt_q_t[$];
   typedef struct {int cyc; int x; int y; int c;} wr_t;
   typedef struct {int cyc; int x0; int y0; int x1; int y1;} ld_t;

   wr_t wq[$];
   ld_t lq[$];
   bit  pause_arr[MAXC];
   int  cyc     = -1;
   int  t_end   = 0;
   int  rst_cyc = -1;
   int  n_checks = 0;
   int  n_fail   = 0;

   // Bresenham pixel list from (x0,y0) to (x1,y1), endpoints included
   function automatic pt_q_t make_line(input int x0, input int y0, input int x1, input int y1);
      pt_q_t q;
      pt_t   p;
      int x = x0, y = y0;
      int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
      int dy = (y1 > y0) ? y0 - y1 : y1 - y0;
      int sx = (x0 < x1) ? 1 : -1;
      int sy = (y0 < y1) ? 1 : -1;
      int err = dx + dy;
      int e2;
      forever begin
         p.x = x; p.y = y;
         q.push_back(p);
         if (x == x1 && y == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
      return q;
   endfunction

   task automatic chk(input bit ok, input string name, input string info);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", name, info);
      end
   endtask

   task automatic push_wr(input int t, input int x, input int y, input int c);
      wr_t w;
      w.cyc = t; w.x = x; w.y = y; w.c = c;
      wq.push_back(w);
   endtask

   task automatic push_ld(input int t, input int p);
      ld_t l;
      l.cyc = t; l.x0 = p; l.y0 = 0; l.x1 = SW - 1 - p; l.y1 = SH - 1;
      lq.push_back(l);
   endtask

   // Line drawer model: loads on ld_start, emits one pixel per cycle, then done
   pt_q_t      dq;
   int         didx  = 0;
   logic [10:0] d_x  = '0;
   logic [10:0] d_y  = '0;
   logic        d_done = 1'b1;
   assign bus.ld_x    = d_x;
   assign bus.ld_y    = d_y;
   assign bus.ld_done = d_done;

   always @(posedge clk) begin
      if (bus.ld_start) begin
         dq     = make_line(int'(bus.ld_x0), int'(bus.ld_y0), int'(bus.ld_x1), int'(bus.ld_y1));
         didx   = 0;
         d_x    <= 11'(dq[0].x);
         d_y    <= 11'(dq[0].y);
         d_done <= 1'b0;
      end else if (!d_done) begin
         if (didx == dq.size() - 1) begin
            d_done <= 1'b1;
         end else begin
            didx = didx + 1;
            d_x  <= 11'(dq[didx].x);
            d_y  <= 11'(dq[didx].y);
         end
      end
   end

   // Monitor: scores writes, drawer loads, held address and reset outputs
   int last_x = 0, last_y = 0;
   bit have_last = 1'b0;
   always @(negedge clk) begin
      wr_t w;
      ld_t l;
      if (reset)
         chk(bus.pix_we == 1'b0 && bus.ld_start == 1'b1 && bus.pix_color == 1'b0, "reset_outputs",
             $sformatf("got we=%0b start=%0b color=%0b, want we=0 start=1 color=0",
                       bus.pix_we, bus.ld_start, bus.pix_color));
      if (cyc >= 0 && cyc < t_end) begin
         while (wq.size() > 0 && wq[0].cyc < cyc) begin
            w = wq.pop_front();
            chk(1'b0, "missed_write", $sformatf("no write at cyc=%0d, want (%0d,%0d) c=%0d",
                                                w.cyc, w.x, w.y, w.c));
         end
         while (lq.size() > 0 && lq[0].cyc < cyc) begin
            l = lq.pop_front();
            chk(1'b0, "missed_load", $sformatf("no ld_start at cyc=%0d", l.cyc));
         end
         if (bus.pix_we) begin
            if (wq.size() == 0) begin
               chk(1'b0, "extra_write", $sformatf("got write at cyc=%0d, want none", cyc));
            end else begin
               w = wq.pop_front();
               chk(w.cyc == cyc && w.x == int'(bus.pix_x) && w.y == int'(bus.pix_y)
                   && w.c == int'(bus.pix_color), "write",
                   $sformatf("got cyc=%0d (%0d,%0d) c=%0d, want cyc=%0d (%0d,%0d) c=%0d",
                             cyc, bus.pix_x, bus.pix_y, bus.pix_color, w.cyc, w.x, w.y, w.c));
               last_x = w.x; last_y = w.y; have_last = 1'b1;
            end
         end else if (!reset && have_last) begin
            chk(int'(bus.pix_x) == last_x && int'(bus.pix_y) == last_y, "held_addr",
                $sformatf("cyc=%0d got (%0d,%0d), want (%0d,%0d)", cyc, bus.pix_x, bus.pix_y,
                          last_x, last_y));
         end
         if (bus.ld_start) begin
            if (lq.size() == 0) begin
               chk(1'b0, "extra_load", $sformatf("got ld_start at cyc=%0d, want none", cyc));
            end else begin
               l = lq.pop_front();
               chk(l.cyc == cyc && l.x0 == int'(bus.ld_x0) && l.y0 == int'(bus.ld_y0)
                   && l.x1 == int'(bus.ld_x1) && l.y1 == int'(bus.ld_y1), "load",
                   $sformatf("got cyc=%0d (%0d,%0d)->(%0d,%0d), want cyc=%0d (%0d,%0d)->(%0d,%0d)",
                             cyc, bus.ld_x0, bus.ld_y0, bus.ld_x1, bus.ld_y1,
                             l.cyc, l.x0, l.y0, l.x1, l.y1));
            end
         end
      end
   end

   initial begin
      pt_q_t ln;
      int t = 0, pos = 0, frames = 0, n;
      bit need_clear = 1'b1, rst_done = 1'b0, forced = 1'b0, aborted;

      for (int i = 0; i < MAXC; i++) pause_arr[i] = ($urandom_range(0, 3) == 0);

      // Timeline model: cycle 0 is the first cycle after reset release
      while (frames < 8) begin
         if (need_clear) begin
            for (int i = 0; i < SW * SH; i++) begin push_wr(t, i % SW, i / SW, 0); t++; end
            need_clear = 1'b0;
         end
         ln = make_line(pos, 0, SW - 1 - pos, SH - 1);
         push_ld(t, pos); t++;
         foreach (ln[i]) begin push_wr(t, ln[i].x, ln[i].y, 1); t++; end
         t++;
         if (!forced) begin
            for (int i = 0; i < 10; i++) pause_arr[t + i] = 1'b1;
            forced = 1'b1;
         end
         n = 0;
         while (n < WC) begin
            if (!pause_arr[t]) n++;
            t++;
         end
         push_ld(t, pos); t++;
         aborted = 1'b0;
         foreach (ln[i]) begin
            if (pos == ST && !rst_done && i == 2) begin
               rst_cyc = t;
               push_ld(t, pos);
               t++;
               rst_done = 1'b1;
               aborted = 1'b1;
               break;
            end
            push_wr(t, ln[i].x, ln[i].y, 0); t++;
         end
         if (aborted) begin
            pos = 0;
            need_clear = 1'b1;
         end else begin
            t += 2;
            pos = (pos + ST > SW - 1) ? 0 : pos + ST;
            frames++;
         end
      end
      t_end = t;

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < t_end; k++) begin
         cyc   = k;
         reset = (k == rst_cyc);
         pause = pause_arr[k];
         @(posedge clk);
         #1;
      end
      cyc = t_end;
      chk(wq.size() == 0, "writes_drained", $sformatf("got %0d pending, want 0", wq.size()));
      chk(lq.size() == 0, "loads_drained", $sformatf("got %0d pending, want 0", lq.size()));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/line_animator.md
LINE_ANIMATOR -- requirements
Module: line_animator

Interface
REQ-001 Parameter SCREEN_W, default 640, visible width in pixels.
REQ-002 Parameter SCREEN_H, default 480, visible height in pixels.
REQ-003 Parameter STEP, default 4, endpoint advance per animation frame in pixels.
REQ-004 Parameter WAIT_CYCLES, default 1_000_000, hold time in clk cycles between draw and erase; minimum 1.
REQ-005 clk  input  1  clock; all state changes on posedge clk.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 pause  input  1  while high, the HOLD state does not expire.
REQ-008 ld_done  input  1  done flag from the downstream line drawer; registered, cleared by ld_start.
REQ-009 ld_x, ld_y  input  11 each  current pixel from the line drawer.
REQ-010 ld_start  output  1  drives the line drawer's synchronous reset/load.
REQ-011 ld_x0, ld_y0, ld_x1, ld_y1  output  11 each  line endpoints presented to the line drawer.
REQ-012 pix_x, pix_y  output  11 each  framebuffer write address.
REQ-013 pix_color  output  1  write data; 1 = white, 0 = black.
REQ-014 pix_we  output  1  framebuffer write enable; one pixel per cycle while high.

Function
REQ-015 The FSM SHALL have states CLEAR, LOAD_D, DRAW, HOLD, LOAD_E, ERASE, ADVANCE.
REQ-016 The animator SHALL hold an 11-bit position register pos; endpoints are ld_x0=pos, ld_y0=0, ld_x1=SCREEN_W-1-pos, ld_y1=SCREEN_H-1.
REQ-017 CLEAR: pix_we=1, pix_color=0, pix_x/pix_y from a raster counter starting at (0,0), x incrementing fastest; after writing (SCREEN_W-1,SCREEN_H-1), next state is LOAD_D.
REQ-018 CLEAR SHALL last exactly SCREEN_W*SCREEN_H cycles, each pixel written exactly once.
REQ-019 LOAD_D and LOAD_E: one cycle each; ld_start=1, pix_we=0; next state DRAW or ERASE respectively.
REQ-020 ld_start SHALL be 0 in all other states.
REQ-021 DRAW: pix_x=ld_x, pix_y=ld_y, pix_color=1, pix_we=~ld_done; on ld_done=1 the next state is HOLD.
REQ-022 ERASE: identical to DRAW but with pix_color=0; on ld_done=1 the next state is ADVANCE.
REQ-023 HOLD: pix_we=0; a wait counter loaded with 0 on entry increments each cycle pause=0 and freezes while pause=1; the state exits to LOAD_E on the cycle the counter equals WAIT_CYCLES-1 with pause=0.
REQ-024 ADVANCE: one cycle, pix_we=0; pos <= (pos+STEP > SCREEN_W-1) ? 0 : pos+STEP; next state LOAD_D.
REQ-025 The comparison pos+STEP SHALL be evaluated at 12 bits so no overflow aliasing occurs.
REQ-026 Endpoints SHALL change only in ADVANCE, keeping them stable from LOAD through the end of ERASE.
REQ-027 pause SHALL have no effect outside HOLD.
REQ-028 In non-writing states, pix_x and pix_y SHALL hold their last value.

Reset
REQ-029 While reset=1: next state CLEAR, raster counter 0, wait counter 0, pos=0, pix_we=0, ld_start=1, pix_color=0.
REQ-030 Reset asserted in any state, including mid-DRAW or mid-ERASE, SHALL abort immediately; the first cycle after release is CLEAR writing (0,0).

Verification (SCREEN_W=8, SCREEN_H=6, STEP=3, WAIT_CYCLES=4; bench includes a line drawer model or instance)
REQ-031 Release reset -> pix_we=1, color 0 for exactly 48 cycles at (0,0),(1,0)..(7,0),(0,1)..(7,5); then ld_start=1 for one cycle with endpoints (0,0)->(7,5).
REQ-032 Draw pass -> writes with color 1 match the drawer pixel sequence ending at (7,5); HOLD lasts 4 cycles with pix_we=0; erase pass repeats the same pixels with color 0.
REQ-033 Successive ADVANCE steps -> pos 0,3,6,0; at pos=6 endpoints are (6,0)->(1,5), and the next frame wraps to (0,0)->(7,5).
REQ-034 pause=1 for 10 cycles during HOLD -> HOLD lasts 14 cycles; pause=1 during DRAW -> no change in timing.
REQ-035 reset pulsed one cycle in the middle of ERASE at pos=3 -> ld_start=1 and pix_we=0 in that cycle, then a full 48-cycle CLEAR, then first line (0,0)->(7,5).
